// File: rtl/gray_seq_checker_pkg.sv
// Shared definitions for the Gray-coded BCD sequence checker.
//   state_t    : checker FSM states (EMPTY, TRACK, LOST)
//   BCD_MAX    : largest legal decoded digit
//   MISS_LIMIT : consecutive flagged samples that drop TRACK into LOST
//   ERR_MAX    : saturation value of the error counter
package gray_seq_checker_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_TRACK = 2'd1,
    ST_LOST  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [1:0] MISS_LIMIT = 2'd3;
  localparam logic [7:0] ERR_MAX    = 8'd255;

endpackage

// File: rtl/gray_seq_checker_gray_to_bcd.sv
// Combinational Gray-to-binary decode of one 4-bit digit.
//   i_gray : Gray code, MSB first (w,x,y,z)
//   o_bcd  : binary value a,b,c,d with a=w, b=a^x, c=b^y, d=c^z
module gray_to_bcd (
  input  logic [3:0] i_gray,
  output logic [3:0] o_bcd
);

  // Each binary bit is the running XOR of all Gray bits above and including it.
  assign o_bcd[3] = i_gray[3];
  assign o_bcd[2] = o_bcd[3] ^ i_gray[2];
  assign o_bcd[1] = o_bcd[2] ^ i_gray[1];
  assign o_bcd[0] = o_bcd[1] ^ i_gray[0];

endmodule

// File: rtl/gray_seq_checker.sv
// Checks a stream of Gray-coded BCD digits for legal counting behaviour.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : gray_in is sampled this cycle
//   gray_in   : Gray-coded BCD digit
//   clr_err   : clears err_count (wins over a simultaneous increment)
//   out_valid : in_valid delayed by one cycle
//   bcd_out   : decoded digit of the last sample
//   range_err : last sample decoded to 10..15
//   step_err  : last sample was not a hold or +1 (mod 10) of the reference
//   lost      : checker is in LOST state
//   err_count : saturating count of flagged samples
module gray_seq_checker
  import gray_seq_checker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] gray_in,
  input  logic       clr_err,
  output logic       out_valid,
  output logic [3:0] bcd_out,
  output logic       range_err,
  output logic       step_err,
  output logic       lost,
  output logic [7:0] err_count
);

  state_t     r_state;
  logic [3:0] r_prev;
  logic [1:0] r_miss;

  logic       r_out_valid;
  logic [3:0] r_bcd;
  logic       r_range_err;
  logic       r_step_err;
  logic       r_lost;
  logic [7:0] r_err_count;

  logic [3:0] w_bcd;
  logic       w_range;
  logic [3:0] w_succ;
  logic       w_step_ok;
  logic       w_step_err;
  logic       w_flag;
  logic [1:0] w_miss_inc;
  state_t     w_state_next;
  logic [3:0] w_prev_next;
  logic [1:0] w_miss_next;

  gray_to_bcd u_gray_to_bcd (
    .i_gray (gray_in),
    .o_bcd  (w_bcd)
  );

  assign w_range    = (w_bcd > BCD_MAX);
  // The 9->0 wrap is a legal successor even though its Gray distance is 3.
  assign w_succ     = (r_prev == BCD_MAX) ? 4'd0 : r_prev + 4'd1;
  assign w_step_ok  = (w_bcd == r_prev) || (w_bcd == w_succ);
  assign w_miss_inc = (r_miss == 2'd3) ? 2'd3 : r_miss + 2'd1;

  // Next-state decision for one valid sample.
  always_comb begin
    w_state_next = r_state;
    w_prev_next  = r_prev;
    w_miss_next  = r_miss;
    w_step_err   = 1'b0;
    if (w_range) begin
      // Out-of-range samples never move the reference digit.
      w_miss_next = w_miss_inc;
      if (r_state == ST_TRACK && r_miss == MISS_LIMIT - 2'd1) begin
        w_state_next = ST_LOST;
      end
    end else begin
      w_prev_next = w_bcd;
      case (r_state)
        ST_TRACK: begin
          if (w_step_ok) begin
            w_miss_next = 2'd0;
          end else begin
            w_step_err  = 1'b1;
            w_miss_next = w_miss_inc;
            if (r_miss == MISS_LIMIT - 2'd1) begin
              w_state_next = ST_LOST;
            end
          end
        end
        default: begin
          // EMPTY and LOST resynchronise on any in-range digit.
          w_miss_next  = 2'd0;
          w_state_next = ST_TRACK;
        end
      endcase
    end
  end

  assign w_flag = w_range | w_step_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_prev      <= 4'd0;
      r_miss      <= 2'd0;
      r_out_valid <= 1'b0;
      r_bcd       <= 4'd0;
      r_range_err <= 1'b0;
      r_step_err  <= 1'b0;
      r_lost      <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_state     <= w_state_next;
        r_prev      <= w_prev_next;
        r_miss      <= w_miss_next;
        r_bcd       <= w_bcd;
        r_range_err <= w_range;
        r_step_err  <= w_step_err;
        r_lost      <= (w_state_next == ST_LOST);
      end
      // Clear is an explicit command and acts on idle cycles too.
      if (clr_err) begin
        r_err_count <= 8'd0;
      end else if (in_valid && w_flag && r_err_count != ERR_MAX) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign bcd_out   = r_bcd;
  assign range_err = r_range_err;
  assign step_err  = r_step_err;
  assign lost      = r_lost;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_gray_seq_checker.sv
module tb_gray_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] gray_in = 4'd0;
  logic       clr_err = 1'b0;
  logic       out_valid;
  logic [3:0] bcd_out;
  logic       range_err;
  logic       step_err;
  logic       lost;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  gray_seq_checker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .clr_err   (clr_err),
    .out_valid (out_valid),
    .bcd_out   (bcd_out),
    .range_err (range_err),
    .step_err  (step_err),
    .lost      (lost),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] gray;
    logic       clr;
    logic       e_ov;
    logic [3:0] e_bcd;
    logic       e_re;
    logic       e_se;
    logic       e_lost;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [3:0] g, input logic c,
                     input logic ov, input logic [3:0] b, input logic re, input logic se,
                     input logic lo, input logic [7:0] cnt);
    vec_t t;
    t = '{r, v, g, c, ov, b, re, se, lo, cnt};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge, sample 1ns after the next.
  task automatic drive(input logic r, input logic v, input logic [3:0] g, input logic c);
    rst = r; in_valid = v; gray_in = g; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [3:0] b,
                           input logic re, input logic se, input logic lo, input logic [7:0] cnt);
    chk({tag, ".out_valid"}, int'(out_valid), int'(ov));
    chk({tag, ".bcd_out"},   int'(bcd_out),   int'(b));
    chk({tag, ".range_err"}, int'(range_err), int'(re));
    chk({tag, ".step_err"},  int'(step_err),  int'(se));
    chk({tag, ".lost"},      int'(lost),      int'(lo));
    chk({tag, ".err_count"}, int'(err_count), int'(cnt));
  endtask

  initial begin
    logic [3:0] stream [11];
    stream = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b0000};

    //   rst vld gray     clr | ov bcd re se lost cnt
    add(1, 0, 4'b0000, 0,  0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) add(0, 1, stream[k], 0, 1, 4'(k % 10), 0, 0, 0, 0);
    add(0, 0, 4'b0000, 0,  0, 0, 0, 0, 0, 0);   // idle: hold
    add(0, 1, 4'b0001, 0,  1, 1, 0, 0, 0, 0);
    add(0, 1, 4'b0011, 0,  1, 2, 0, 0, 0, 0);
    add(0, 1, 4'b0010, 0,  1, 3, 0, 0, 0, 0);
    add(0, 1, 4'b0111, 0,  1, 5, 0, 1, 0, 1);   // 3 -> 5 illegal
    add(0, 1, 4'b0101, 0,  1, 6, 0, 0, 0, 1);   // 5 -> 6 legal
    add(0, 1, 4'b1111, 0,  1, 10, 1, 0, 0, 2);  // range error, prev stays 6
    add(0, 1, 4'b0100, 0,  1, 7, 0, 0, 0, 2);   // 6 -> 7 legal
    add(0, 1, 4'b0000, 0,  1, 0, 0, 1, 0, 3);   // miss 1
    add(0, 1, 4'b0111, 0,  1, 5, 0, 1, 0, 4);   // miss 2
    add(0, 1, 4'b0011, 0,  1, 2, 0, 1, 1, 5);   // miss 3 -> LOST
    add(0, 0, 4'b1111, 0,  0, 2, 0, 1, 1, 5);   // idle holds flags
    add(0, 1, 4'b0100, 0,  1, 7, 0, 0, 0, 5);   // resync prev=7
    add(0, 1, 4'b1100, 0,  1, 8, 0, 0, 0, 5);   // 7 -> 8 legal
    add(0, 0, 4'b0000, 1,  0, 8, 0, 0, 0, 0);   // clear on idle
    add(1, 1, 4'b0111, 1,  0, 0, 0, 0, 0, 0);   // reset overrides valid
    add(0, 1, 4'b1101, 0,  1, 9, 0, 0, 0, 0);   // EMPTY sample
    add(0, 1, 4'b0000, 0,  1, 0, 0, 0, 0, 0);   // 9 -> 0 wrap legal

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].gray, vecs[i].clr);
      $display("vec %0d: rst=%0b vld=%0b gray=%b -> ov=%0b bcd=%0d re=%0b se=%0b lost=%0b cnt=%0d",
               i, vecs[i].rst, vecs[i].vld, vecs[i].gray, out_valid, bcd_out,
               range_err, step_err, lost, err_count);
      check_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_bcd, vecs[i].e_re,
                vecs[i].e_se, vecs[i].e_lost, vecs[i].e_cnt);
    end

    // Saturation: range errors from EMPTY never reach LOST and count every sample.
    drive(1, 0, 4'b0000, 0);
    for (int k = 0; k < 255; k++) drive(0, 1, 4'b1111, 0);
    $display("sat fill: cnt=%0d re=%0b lost=%0b", err_count, range_err, lost);
    check_all("sat_fill", 1, 10, 1, 0, 0, 8'd255);
    drive(0, 1, 4'b1111, 0);
    $display("sat hold: cnt=%0d", err_count);
    chk("sat_hold.err_count", int'(err_count), 255);
    drive(0, 1, 4'b1111, 1);
    $display("sat clr: cnt=%0d", err_count);
    chk("sat_clr.err_count", int'(err_count), 0);
    drive(0, 1, 4'b1111, 0);
    $display("sat next: cnt=%0d", err_count);
    chk("sat_next.err_count", int'(err_count), 1);
    drive(0, 1, 4'b0111, 0);
    $display("empty load: bcd=%0d se=%0b cnt=%0d", bcd_out, step_err, err_count);
    check_all("empty_load", 1, 5, 0, 0, 0, 8'd1);

    // Range errors in TRACK: third consecutive one enters LOST.
    drive(0, 1, 4'b1111, 0);
    drive(0, 1, 4'b1111, 0);
    chk("trk_range2.lost", int'(lost), 0);
    drive(0, 1, 4'b1111, 0);
    $display("track range x3: lost=%0b cnt=%0d", lost, err_count);
    check_all("trk_range3", 1, 10, 1, 0, 1, 8'd4);
    drive(0, 1, 4'b0111, 0);
    $display("lost resync: bcd=%0d lost=%0b se=%0b", bcd_out, lost, step_err);
    check_all("lost_resync", 1, 5, 0, 0, 0, 8'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_seq_checker.md
GRAY_SEQ_CHECKER -- requirements
Module: gray_seq_checker

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 The port list SHALL be:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  gray_in is sampled this cycle.
- gray_in  input  4  Gray-coded BCD digit, MSB first: w,x,y,z.
- clr_err  input  1  clears err_count.
- out_valid  output  1  registered; the outputs below describe the last sample.
- bcd_out  output  4  decoded digit: a=w, b=a^x, c=b^y, d=c^z.
- range_err  output  1  decoded value is greater than 9.
- step_err  output  1  illegal successor of the previous digit.
- lost  output  1  checker is in LOST state.
- err_count  output  8  saturating count of flagged samples.
REQ-003 There SHALL be no parameters.

Function
REQ-004 The block SHALL register all outputs with 1-cycle latency: a sample taken at edge N appears after edge N+1.
REQ-005 out_valid SHALL equal in_valid delayed one cycle; when in_valid=0, every other output SHALL hold its value.
REQ-006 The decode SHALL be purely bitwise XOR; range_err SHALL be 1 iff bcd_out is 10..15.
REQ-007 The FSM SHALL have three states: EMPTY (no reference digit), TRACK (reference held in prev), LOST.
REQ-008 In EMPTY, a valid in-range sample SHALL load prev, set step_err=0 and go to TRACK; an out-of-range sample SHALL stay in EMPTY.
REQ-009 In TRACK, a sample is legal iff value == prev (hold) or value == (prev+1) mod 10; the 9->0 wrap SHALL be legal even though the Gray distance is 3.
REQ-010 In TRACK, an illegal in-range sample SHALL set step_err=1 and still update prev to the new value.
REQ-011 An out-of-range sample SHALL set range_err=1, force step_err=0, and leave prev unchanged.
REQ-012 A miss counter (2 bits) SHALL count consecutive flagged samples (step_err or range_err) and reset to 0 on a legal sample.
REQ-013 The third consecutive flagged sample SHALL move the FSM from TRACK to LOST; lost SHALL be 1 while in LOST.
REQ-014 In LOST, samples are not step-checked (step_err=0); the first in-range sample SHALL load prev, clear the miss counter and go to TRACK.
REQ-015 err_count SHALL increment by 1 per flagged sample and saturate at 255.
REQ-016 clr_err SHALL set err_count to 0 and take priority over a simultaneous increment.
REQ-017 in_valid=0 cycles SHALL not affect prev, the miss counter or the FSM state.

Reset
REQ-018 While rst=1, the block SHALL be in EMPTY with prev=0, miss=0, out_valid=0, bcd_out=0, range_err=0, step_err=0, lost=0 and err_count=0.
REQ-019 Reset asserted mid-stream SHALL override in_valid and clr_err; the first sample after reset SHALL be treated as an EMPTY-state sample.

Structure
REQ-020 A shared package SHALL hold the FSM state enum (EMPTY, TRACK, LOST), BCD_MAX=9, MISS_LIMIT=3 and ERR_MAX=255.
REQ-021 The gray-to-BCD decode SHALL be a separate combinational sub-module, gray_to_bcd, the inverse of the existing converter.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Gray stream for 0..9 then 0 (0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,0000) -> bcd_out 0..9,0; all error flags 0; err_count 0.
- After 3 (0010), drive 5 (0111) -> step_err=1, err_count=1; then 6 (0101) -> step_err=0, miss cleared.
- Drive 1111 (decodes to 10) in TRACK -> range_err=1, step_err=0, prev unchanged, so the next legal successor is accepted.
- Three consecutive illegal samples -> lost=1 on the third output; then 0100 -> lost=0, prev=7, TRACK.
- Force err_count to 255 with repeated errors, then another error -> stays 255; clr_err together with an error -> 0.
- Assert rst mid-stream with in_valid=1 -> all outputs 0 next cycle; the first post-reset sample 1101 gives step_err=0.
